// File: rtl/rom_fetch_sequencer_if.sv
// Fetch bundle between rom_fetch_sequencer, the combinational program ROM and the execute stage.
// master = sequencer side, slave = ROM/execute side.
interface rom_fetch_sequencer_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28
);
    logic [ADDR_WIDTH-1:0]  rom_address;
    logic [INSTR_WIDTH-1:0] rom_instruction;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instruction_valid;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   stall;
    logic                   branch_taken;
    logic [ADDR_WIDTH-1:0]  branch_target;
    logic                   busy_wait;

    modport master (
        output rom_address,
        output instruction,
        output instruction_valid,
        output pc,
        output busy_wait,
        input  rom_instruction,
        input  stall,
        input  branch_taken,
        input  branch_target
    );

    modport slave (
        input  rom_address,
        input  instruction,
        input  instruction_valid,
        input  pc,
        input  busy_wait,
        output rom_instruction,
        output stall,
        output branch_taken,
        output branch_target
    );
endinterface

// File: rtl/rom_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, registers ROM words for execute, handles stall/branch.
// Define NOP_WAIT_EN to make a NOP with a nonzero literal N insert N bubble cycles (WAIT state).
module rom_fetch_sequencer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28
`ifdef NOP_WAIT_EN
    ,
    parameter logic [7:0] NOP_OPCODE = 8'd0
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    rom_fetch_sequencer_if.master bus
);

    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   valid_q;
    logic [ADDR_WIDTH-1:0]  issue_pc_q;

    logic take_branch;
    logic do_fetch;
    logic bubble;

`ifdef NOP_WAIT_EN
    localparam int LIT_WIDTH = 24;

    typedef enum logic {
        FETCH,
        WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [LIT_WIDTH-1:0] wait_count_q, wait_count_d;
    logic                 busy_q, busy_d;

    logic [7:0]           opcode;
    logic [LIT_WIDTH-1:0] literal;
    logic                 delay_nop;

    assign opcode    = bus.rom_instruction[INSTR_WIDTH-1 -: 8];
    assign literal   = bus.rom_instruction[LIT_WIDTH-1:0];
    assign delay_nop = (opcode == NOP_OPCODE) && (literal != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            wait_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_count_q <= wait_count_d;
            busy_q       <= busy_d;
        end
    end

    // The counter is loaded with N when the NOP issues and the WAIT edges count it down to zero,
    // giving exactly N bubble cycles; the edge that sees zero performs the next fetch.
    always_comb begin
        state_d      = state_q;
        wait_count_d = wait_count_q;
        busy_d       = 1'b0;
        take_branch  = 1'b0;
        do_fetch     = 1'b0;
        bubble       = 1'b0;
        unique case (state_q)
            FETCH: begin
                take_branch = valid_q && bus.branch_taken;
                do_fetch    = !take_branch && !bus.stall;
            end
            WAIT: begin
                if (wait_count_q == '0) begin
                    do_fetch = 1'b1;
                    state_d  = FETCH;
                end else begin
                    bubble       = 1'b1;
                    busy_d       = 1'b1;
                    wait_count_d = wait_count_q - 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase
        if (do_fetch && delay_nop) begin
            state_d      = WAIT;
            wait_count_d = literal;
        end
    end

    assign bus.busy_wait = busy_q;
`else
    always_comb begin
        take_branch = valid_q && bus.branch_taken;
        do_fetch    = !take_branch && !bus.stall;
    end

    assign bubble        = 1'b0;
    assign bus.busy_wait = 1'b0;
`endif

    // A taken branch squashes the issue slot; a stall holds everything, including the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            issue_pc_q <= '0;
        end else if (take_branch) begin
            pc_q    <= bus.branch_target;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (do_fetch) begin
            instr_q    <= bus.rom_instruction;
            issue_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_q + 1'b1;
        end else if (bubble) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.rom_address       = pc_q;
    assign bus.instruction       = instr_q;
    assign bus.instruction_valid = valid_q;
    assign bus.pc                = issue_pc_q;

endmodule
